// File: rtl/shot_judge_pkg.sv
// Shared types and coordinate helpers for the own-fleet board store and shot referee.
package shot_judge_pkg;

    localparam int GRID_N_DEF     = 10;
    localparam int SHIP_CELLS_DEF = 20;

    typedef enum logic [1:0] {EMPTY = 2'd0, SHIP = 2'd1, SHIP_HIT = 2'd2, MISS = 2'd3} cell_t;
    typedef enum logic [1:0] {RES_MISS = 2'd0, RES_HIT = 2'd1, RES_REPEAT = 2'd2, RES_SUNK = 2'd3} res_t;
    typedef enum logic [2:0] {S_CLEAR, S_PLACE, S_READY, S_LOOKUP, S_RESP, S_DEFEAT} state_t;

    function automatic logic pos_in_grid(input logic [7:0] pos, input logic [3:0] n);
        return (pos[7:4] < n) && (pos[3:0] < n);
    endfunction

    // Out-of-grid coordinates wrap to a meaningless address; callers gate with pos_in_grid.
    function automatic logic [6:0] pos_addr(input logic [7:0] pos, input logic [3:0] n);
        return ({3'b000, pos[7:4]} * {3'b000, n}) + {3'b000, pos[3:0]};
    endfunction

endpackage

// File: rtl/shot_judge_if.sv
// Opponent shot handshake and result return between logic_ctl and shot_judge.
interface shot_judge_if;
    import shot_judge_pkg::*;

    logic       shot_valid;
    logic [7:0] shot_pos;
    logic       shot_ready;
    logic       res_valid;
    res_t       res_code;

    modport master (output shot_valid, shot_pos, input shot_ready, res_valid, res_code);
    modport slave  (input shot_valid, shot_pos, output shot_ready, res_valid, res_code);

endinterface

// File: rtl/shot_judge_board_ram.sv
// 128x2 board memory: one synchronous write port, two synchronous read ports (judge, renderer).
module shot_judge_board_ram
    import shot_judge_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  cell_t      wdata,
    input  logic [6:0] raddr_a,
    output cell_t      rdata_a,
    input  logic [6:0] raddr_b,
    output cell_t      rdata_b
);

    cell_t mem [0:127];

    // Reads return the pre-write contents when addresses collide.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/shot_judge.sv
// Own-fleet board store and shot referee with a registered renderer read port.
//   state    | meaning
//   S_CLEAR  | sweeping EMPTY into every cell, busy
//   S_PLACE  | accepting ship cell placements, waiting for arm
//   S_READY  | accepting an opponent shot
//   S_LOOKUP | board read of the latched shot in flight
//   S_RESP   | result presented, board marked
//   S_DEFEAT | fleet destroyed, holds until clear
module shot_judge
    import shot_judge_pkg::*;
#(
    parameter int GRID_N     = GRID_N_DEF,
    parameter int SHIP_CELLS = SHIP_CELLS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        place_req,
    input  logic [7:0]  place_pos,
    output logic        place_ack,
    output logic        place_ok,
    output logic [4:0]  ship_cnt,
    output logic        place_done,
    input  logic        arm,
    shot_judge_if.slave shot,
    output logic [4:0]  remaining,
    output logic        defeat,
    output logic        busy,
    input  logic [7:0]  rd_pos,
    output cell_t       rd_cell
);

    localparam logic [3:0] N4       = 4'(GRID_N);
    localparam logic [6:0] LAST_IDX = 7'(GRID_N * GRID_N - 1);
    localparam logic [4:0] FLEET    = 5'(SHIP_CELLS);

    state_t     state_q, state_n;
    logic [6:0] sweep_idx_q, pend_addr_q, shot_addr_q;
    logic       pend_q, pend_in_grid_q, pend_haz_q, shot_in_grid_q, rd_ok_q, defeat_q;
    logic [4:0] ship_cnt_q, remaining_q;

    cell_t      judge_cell, view_cell, wdata;
    logic       we;
    logic [6:0] waddr, judge_addr, rd_addr;
    logic       shot_ready_c, res_valid_c;
    res_t       res_code_c;

    logic place_take, place_accept, arm_take, shot_take, resp_ship, resp_empty, sunk;

    assign place_done   = (ship_cnt_q == FLEET);
    assign place_take   = place_req && (state_q == S_PLACE) && !clear;
    // Placement is resolved the cycle after the request, once the cell has been read.
    assign place_accept = pend_q && !clear && pend_in_grid_q && !pend_haz_q &&
                          (judge_cell == EMPTY) && (ship_cnt_q < FLEET);
    assign arm_take     = arm && (state_q == S_PLACE) && place_done && !clear;
    assign shot_take    = shot.shot_valid && (state_q == S_READY) && !clear;
    assign resp_ship    = (state_q == S_RESP) && shot_in_grid_q && (judge_cell == SHIP);
    assign resp_empty   = (state_q == S_RESP) && shot_in_grid_q && (judge_cell == EMPTY);
    assign sunk         = resp_ship && (remaining_q == 5'd1);

    assign judge_addr = (state_q == S_PLACE) ? pos_addr(place_pos, N4) : shot_addr_q;
    assign rd_addr    = pos_addr(rd_pos, N4);

    shot_judge_board_ram u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (judge_addr),
        .rdata_a (judge_cell),
        .raddr_b (rd_addr),
        .rdata_b (view_cell)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_CLEAR;
        else      state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_CLEAR:  if (sweep_idx_q == LAST_IDX) state_n = S_PLACE;
            S_PLACE:  if (arm_take) state_n = S_READY;
            S_READY:  if (shot.shot_valid) state_n = S_LOOKUP;
            S_LOOKUP: state_n = S_RESP;
            S_RESP:   state_n = sunk ? S_DEFEAT : S_READY;
            S_DEFEAT: state_n = S_DEFEAT;
            default:  state_n = S_CLEAR;
        endcase
        if (clear) state_n = S_CLEAR;
    end

    always_comb begin
        we           = 1'b0;
        waddr        = pend_addr_q;
        wdata        = SHIP;
        busy         = 1'b0;
        shot_ready_c = 1'b0;
        res_valid_c  = 1'b0;
        res_code_c   = RES_MISS;
        case (state_q)
            S_CLEAR: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = sweep_idx_q;
                wdata = EMPTY;
            end
            S_READY: shot_ready_c = 1'b1;
            S_RESP: begin
                if (!clear) begin
                    res_valid_c = 1'b1;
                    waddr       = shot_addr_q;
                    if (resp_empty) begin
                        res_code_c = RES_MISS;
                        we         = 1'b1;
                        wdata      = MISS;
                    end else if (resp_ship) begin
                        res_code_c = (remaining_q == 5'd1) ? RES_SUNK : RES_HIT;
                        we         = 1'b1;
                        wdata      = SHIP_HIT;
                    end else begin
                        res_code_c = RES_REPEAT;
                    end
                end
            end
            default: ;
        endcase
        if (place_accept) begin
            we    = 1'b1;
            waddr = pend_addr_q;
            wdata = SHIP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            sweep_idx_q <= 7'd0;
            ship_cnt_q  <= 5'd0;
            remaining_q <= 5'd0;
            defeat_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_haz_q  <= 1'b0;
        end else begin
            if (state_q == S_CLEAR) sweep_idx_q <= sweep_idx_q + 7'd1;
            pend_q <= place_take;
            // A back-to-back request to the cell being written now read stale EMPTY.
            pend_haz_q <= place_take && place_accept && (pos_addr(place_pos, N4) == pend_addr_q);
            if (place_accept) ship_cnt_q <= ship_cnt_q + 5'd1;
            if (arm_take) remaining_q <= FLEET;
            else if (resp_ship && (remaining_q != 5'd0)) remaining_q <= remaining_q - 5'd1;
            if (sunk) defeat_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_addr_q    <= 7'd0;
            pend_in_grid_q <= 1'b0;
            shot_addr_q    <= 7'd0;
            shot_in_grid_q <= 1'b0;
            rd_ok_q        <= 1'b0;
        end else begin
            if (place_take) begin
                pend_addr_q    <= pos_addr(place_pos, N4);
                pend_in_grid_q <= pos_in_grid(place_pos, N4);
            end
            if (shot_take) begin
                shot_addr_q    <= pos_addr(shot.shot_pos, N4);
                shot_in_grid_q <= pos_in_grid(shot.shot_pos, N4);
            end
            rd_ok_q <= pos_in_grid(rd_pos, N4) && (state_q != S_CLEAR) && !clear;
        end
    end

    assign rd_cell         = rd_ok_q ? view_cell : EMPTY;
    assign place_ack       = pend_q;
    assign place_ok        = place_accept;
    assign ship_cnt        = ship_cnt_q;
    assign remaining       = remaining_q;
    assign defeat          = defeat_q;
    assign shot.shot_ready = shot_ready_c;
    assign shot.res_valid  = res_valid_c;
    assign shot.res_code   = res_code_c;

endmodule
